// File: rtl/rastreador_posicao_pkg.sv
// Shared types and default grid constants for the maze position tracker.
package rastreio_pkg;

  typedef enum logic [1:0] {
    N = 2'd0,
    E = 2'd1,
    S = 2'd2,
    W = 2'd3
  } dir_t;

  localparam logic [2:0] ORI_INVALIDA_MIN = 3'd4;

  localparam int unsigned LARG_PADRAO      = 10;
  localparam int unsigned ALT_PADRAO       = 10;
  localparam int unsigned X0_PADRAO        = 0;
  localparam int unsigned Y0_PADRAO        = 0;
  localparam int unsigned XS_PADRAO        = 9;
  localparam int unsigned YS_PADRAO        = 9;
  localparam int unsigned PROF_HIST_PADRAO = 16;
  localparam int unsigned W_PASSOS_PADRAO  = 16;

endpackage

// File: rtl/fifo_historico.sv
// Step-direction history FIFO; a push into a full FIFO drops the oldest entry.
module fifo_historico #(
  parameter int unsigned PROF = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [1:0] din,
  input  logic       pop,
  output logic [1:0] dado,
  output logic       vld,
  output logic       vazio,
  output logic       ovf
);

  localparam int unsigned AW = (PROF > 1) ? $clog2(PROF) : 1;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(PROF);

  logic [1:0]    mem [PROF];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          cheio;
  logic          pop_ok;
  logic          descarta;

  assign vazio    = (cnt == '0);
  assign cheio    = (cnt == CNT_MAX);
  assign pop_ok   = pop & ~vazio;
  // Only a push that is not paired with a real pop can overflow.
  assign descarta = push & ~pop_ok & cheio;

  // NOTE: the storage array has no reset; only pointers and count define its contents.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      dado   <= '0;
      vld    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      vld <= pop_ok;
      if (pop_ok) dado <= mem[rd_ptr];
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok || descarta) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop_ok && !cheio)      cnt <= cnt + (AW+1)'(1);
      else if (pop_ok && !push)           cnt <= cnt - (AW+1)'(1);
      if (descarta) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/rastreador_posicao.sv
// Tracks the robot's grid cell from step requests, counts steps, flags exit arrival and logs history.
module rastreador_posicao
  import rastreio_pkg::*;
#(
  parameter int unsigned LARG      = LARG_PADRAO,
  parameter int unsigned ALT       = ALT_PADRAO,
  parameter int unsigned X0        = X0_PADRAO,
  parameter int unsigned Y0        = Y0_PADRAO,
  parameter int unsigned XS        = XS_PADRAO,
  parameter int unsigned YS        = YS_PADRAO,
  parameter int unsigned PROF_HIST = PROF_HIST_PADRAO,
  parameter int unsigned W_PASSOS  = W_PASSOS_PADRAO,
  localparam int unsigned XW = (LARG > 1) ? $clog2(LARG) : 1,
  localparam int unsigned YW = (ALT > 1) ? $clog2(ALT) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                avancar,
  input  logic [2:0]          orientacao,
  input  logic                hist_rd,
  output logic [XW-1:0]       pos_x,
  output logic [YW-1:0]       pos_y,
  output logic [W_PASSOS-1:0] passos,
  output logic                chegou,
  output logic                erro_mov,
  output logic [1:0]          hist_dado,
  output logic                hist_vld,
  output logic                hist_vazio,
  output logic                hist_ovf
);

  localparam logic CHEGOU_INI = (X0 == XS) && (Y0 == YS);

  logic          avancar_q;
  logic          ev;
  logic          tentativa;
  logic          ori_invalida;
  logic          fora;
  logic          aceito;
  logic          rejeitado;
  logic [XW-1:0] alvo_x;
  logic [YW-1:0] alvo_y;

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    alvo_x = pos_x;
    alvo_y = pos_y;
    fora   = 1'b0;
    case (dir_t'(orientacao[1:0]))
      N: if (pos_y == YW'(ALT - 1)) fora = 1'b1; else alvo_y = pos_y + YW'(1);
      E: if (pos_x == XW'(LARG - 1)) fora = 1'b1; else alvo_x = pos_x + XW'(1);
      S: if (pos_y == '0) fora = 1'b1; else alvo_y = pos_y - YW'(1);
      W: if (pos_x == '0) fora = 1'b1; else alvo_x = pos_x - XW'(1);
    endcase
  end

  assign ev           = avancar & ~avancar_q;
  assign tentativa    = ev & ~chegou;
  assign ori_invalida = (orientacao >= ORI_INVALIDA_MIN);
  assign aceito       = tentativa & ~ori_invalida & ~fora;
  assign rejeitado    = tentativa & (ori_invalida | fora);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avancar_q <= 1'b0;
      pos_x     <= XW'(X0);
      pos_y     <= YW'(Y0);
      passos    <= '0;
      chegou    <= CHEGOU_INI;
      erro_mov  <= 1'b0;
    end else begin
      avancar_q <= avancar;
      erro_mov  <= rejeitado;
      if (aceito) begin
        pos_x  <= alvo_x;
        pos_y  <= alvo_y;
        chegou <= (alvo_x == XW'(XS)) && (alvo_y == YW'(YS));
        if (passos != '1) passos <= passos + W_PASSOS'(1);
      end
    end
  end

  fifo_historico #(
    .PROF (PROF_HIST)
  ) u_hist (
    .clock (clock),
    .reset (reset),
    .push  (aceito),
    .din   (orientacao[1:0]),
    .pop   (hist_rd),
    .dado  (hist_dado),
    .vld   (hist_vld),
    .vazio (hist_vazio),
    .ovf   (hist_ovf)
  );

endmodule
